// File: rtl/sram_like_responder_pkg.sv
// Shared encodings for the sram-like responder: transfer-size codes and response entry width.
package sram_like_responder_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int         RESP_W    = 32;
endpackage

// File: rtl/sram_like_responder_fifo.sv
// In-order response FIFO, registered head; push and pop may coincide even when full.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= ptr_next(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign o_head_dat = r_mem[r_rptr];
endmodule

// File: rtl/sram_like_responder.sv
// Sram-like memory responder: accepts up to MAX_OUT requests, data_ok 1+RESP_DELAY cycles after accept.
// No response backpressure; addr_ok drops while MAX_OUT responses are owed.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int MAX_OUT    = 2,
    parameter int RESP_DELAY = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic              r_live;
    logic [CW-1:0]     r_count;
    logic              r_cap_v;
    logic              r_cap_wr;
    logic [3:0]        r_dly;

    logic              w_accept;
    logic              w_any;
    logic              w_push;
    logic              w_pop_fifo;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [RESP_W-1:0] w_cap_dat;
    logic [RESP_W-1:0] w_head_dat;
    logic              w_unused;

    // r_live keeps addr_ok low while reset is held, independent of the count.
    assign addr_ok   = r_live && (r_count < CW'(MAX_OUT));
    assign w_accept  = req && addr_ok;
    assign ram_en    = w_accept;
    assign ram_we    = (w_accept && wr) ? wstrb : 4'h0;
    assign ram_addr  = {addr[31:2], 2'b00};
    assign ram_wdata = wdata;

    assign w_cap_dat = r_cap_wr ? 32'h0 : ram_rdata;

    // The capture stage acts as the FIFO tail: with an empty FIFO the captured
    // entry is the head and can be returned in the same cycle without a push.
    assign w_any      = !w_fifo_empty || r_cap_v;
    assign data_ok    = w_any && (r_dly == 4'(RESP_DELAY));
    assign rdata      = !data_ok ? 32'h0 : (w_fifo_empty ? w_cap_dat : w_head_dat);
    assign w_pop_fifo = data_ok && !w_fifo_empty;
    assign w_push     = r_cap_v && !(data_ok && w_fifo_empty);

    assign w_unused = ^{size, addr[1:0], w_fifo_full};

    resp_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (RESP_W)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_push_dat (w_cap_dat),
        .i_pop      (w_pop_fifo),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head_dat (w_head_dat)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_live   <= 1'b0;
            r_count  <= '0;
            r_cap_v  <= 1'b0;
            r_cap_wr <= 1'b0;
            r_dly    <= 4'h0;
        end else begin
            r_live   <= 1'b1;
            r_cap_v  <= w_accept;
            r_cap_wr <= wr;
            case ({w_accept, data_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (data_ok || !w_any) begin
                r_dly <= 4'h0;
            end else if (r_dly != 4'(RESP_DELAY)) begin
                r_dly <= r_dly + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: a RESP_DELAY=0 and a RESP_DELAY=3 responder share stimulus, each with its own RAM.
module tb_sram_like_responder;
    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic        addr_ok0, data_ok0, ram_en0;
    logic [31:0] rdata0, ram_addr0, ram_wdata0, ram_rdata0;
    logic [3:0]  ram_we0;
    logic        addr_ok3, data_ok3, ram_en3;
    logic [31:0] rdata3, ram_addr3, ram_wdata3, ram_rdata3;
    logic [3:0]  ram_we3;

    logic        pre_vld;
    logic [31:0] pre_addr;
    logic [31:0] pre_dat;
    logic [31:0] mem0 [256];
    logic [31:0] mem3 [256];

    int vecs = 0;
    int errs = 0;

    bit exp_aok [14] = '{1,1,0,0,0,1,0,0,0,1,1,1,1,1};
    bit exp_dok [14] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0};

    sram_like_responder #(.MAX_OUT(2), .RESP_DELAY(0)) dut0 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0),
        .rdata(rdata0), .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    sram_like_responder #(.MAX_OUT(2), .RESP_DELAY(3)) dut3 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok3), .data_ok(data_ok3),
        .rdata(rdata3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Write-first RAM models with a one-cycle registered read.
    always @(posedge clk) begin
        if (pre_vld) begin
            mem0[pre_addr[9:2]] <= pre_dat;
            mem3[pre_addr[9:2]] <= pre_dat;
        end else begin
            if (ram_en0) begin
                mem0[ram_addr0[9:2]] <= merge(mem0[ram_addr0[9:2]], ram_we0, ram_wdata0);
                ram_rdata0           <= merge(mem0[ram_addr0[9:2]], ram_we0, ram_wdata0);
            end
            if (ram_en3) begin
                mem3[ram_addr3[9:2]] <= merge(mem3[ram_addr3[9:2]], ram_we3, ram_wdata3);
                ram_rdata3           <= merge(mem3[ram_addr3[9:2]], ram_we3, ram_wdata3);
            end
        end
    end

    function automatic logic [31:0] stream_val(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_vld = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_vld = 1'b0;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        vecs++; if (addr_ok0 !== 1'b0) begin errs++; $display("FAIL rst_addr_ok got=%0b exp=0", addr_ok0); end
        vecs++; if (data_ok0 !== 1'b0) begin errs++; $display("FAIL rst_data_ok got=%0b exp=0", data_ok0); end
        vecs++; if (rdata0 !== 32'h0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", rdata0); end
        vecs++; if (ram_en0 !== 1'b0 || ram_we0 !== 4'h0) begin errs++; $display("FAIL rst_ram got en=%0b we=%h exp en=0 we=0", ram_en0, ram_we0); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk); #1;
        vecs++; if (addr_ok0 !== 1'b1) begin errs++; $display("FAIL rst_release_addr_ok got=%0b exp=1", addr_ok0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 32'h1C00_0000, 4'h0, 32'h0); #1;
        vecs++; if (addr_ok3 !== 1'b1) begin errs++; $display("FAIL mid_aok0 got=%0b exp=1", addr_ok3); end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h1C00_0004, 4'h0, 32'h0); #1;
        vecs++; if (addr_ok3 !== 1'b1) begin errs++; $display("FAIL mid_aok1 got=%0b exp=1", addr_ok3); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        vecs++; if (addr_ok3 !== 1'b0 || data_ok3 !== 1'b0) begin errs++; $display("FAIL mid_full got aok=%0b dok=%0b exp aok=0 dok=0", addr_ok3, data_ok3); end
        resetn = 1'b0; #1;
        vecs++; if (addr_ok3 !== 1'b0 || data_ok3 !== 1'b0) begin errs++; $display("FAIL mid_in_reset got aok=%0b dok=%0b exp 0 0", addr_ok3, data_ok3); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            vecs++; if (data_ok3 !== 1'b0 || data_ok0 !== 1'b0) begin errs++; $display("FAIL mid_stale c=%0d got dok3=%0b dok0=%0b exp 0 0", c, data_ok3, data_ok0); end
            vecs++; if (addr_ok3 !== 1'b1) begin errs++; $display("FAIL mid_after_aok c=%0d got=%0b exp=1", c, addr_ok3); end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        preload(32'h1C00_0000, 32'h0280_0C0C);
        drive(1'b1, 1'b0, 32'h1C00_0000, 4'h0, 32'h0); #1;
        vecs++; if (ram_en0 !== 1'b1 || ram_we0 !== 4'h0) begin errs++; $display("FAIL sr_ram_en got en=%0b we=%h exp en=1 we=0", ram_en0, ram_we0); end
        vecs++; if (data_ok0 !== 1'b0) begin errs++; $display("FAIL sr_early_dok got=%0b exp=0", data_ok0); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        vecs++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h0280_0C0C) begin errs++; $display("FAIL sr_resp got dok=%0b rdata=%h exp dok=1 rdata=02800c0c", data_ok0, rdata0); end
        @(negedge clk); #1;
        vecs++; if (data_ok0 !== 1'b0 || rdata0 !== 32'h0) begin errs++; $display("FAIL sr_after got dok=%0b rdata=%h exp 0 0", data_ok0, rdata0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] v [3];
        int k;
        int r;
        a = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0008};
        v = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        do_reset();
        for (int i = 0; i < 3; i++) preload(a[i], v[i]);
        k = 0; r = 0;
        for (int c = 0; c < 14; c++) begin
            if (k < 3) drive(1'b1, 1'b0, a[k], 4'h0, 32'h0);
            else       drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #1;
            vecs++; if (addr_ok3 !== exp_aok[c]) begin errs++; $display("FAIL b2b_aok c=%0d got=%0b exp=%0b", c, addr_ok3, exp_aok[c]); end
            vecs++; if (data_ok3 !== exp_dok[c]) begin errs++; $display("FAIL b2b_dok c=%0d got=%0b exp=%0b", c, data_ok3, exp_dok[c]); end
            if (exp_dok[c]) begin
                vecs++; if (rdata3 !== v[r]) begin errs++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, rdata3, v[r]); end
                r++;
            end
            if (exp_aok[c] && k < 3) k++;
            @(negedge clk);
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        preload(32'h1C00_0010, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 32'h1C00_0010, 4'b0011, 32'hAAAA_5555); #1;
        vecs++; if (ram_en0 !== 1'b1 || ram_we0 !== 4'b0011 || ram_wdata0 !== 32'hAAAA_5555) begin errs++; $display("FAIL wr_ram got en=%0b we=%h wd=%h exp 1 3 aaaa5555", ram_en0, ram_we0, ram_wdata0); end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h1C00_0010, 4'b1111, 32'h0); #1;
        vecs++; if (ram_we0 !== 4'h0 || addr_ok0 !== 1'b1) begin errs++; $display("FAIL rd_ram got we=%h aok=%0b exp we=0 aok=1", ram_we0, addr_ok0); end
        vecs++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h0) begin errs++; $display("FAIL wr_resp got dok=%0b rdata=%h exp 1 0", data_ok0, rdata0); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        vecs++; if (data_ok0 !== 1'b1 || rdata0 !== 32'hFFFF_5555) begin errs++; $display("FAIL raw_resp got dok=%0b rdata=%h exp 1 ffff5555", data_ok0, rdata0); end
        @(negedge clk); #1;
        vecs++; if (data_ok0 !== 1'b0) begin errs++; $display("FAIL wr_drain got dok=%0b exp=0", data_ok0); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 16; i++) preload(32'h1C00_0020 + 32'(4 * i), stream_val(i));
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) drive(1'b1, 1'b0, 32'h1C00_0020 + 32'(4 * c), 4'h0, 32'h0);
            else        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #1;
            vecs++; if (addr_ok0 !== 1'b1) begin errs++; $display("FAIL st_aok c=%0d got=%0b exp=1", c, addr_ok0); end
            if (c == 0) begin
                vecs++; if (data_ok0 !== 1'b0) begin errs++; $display("FAIL st_first_dok got=%0b exp=0", data_ok0); end
            end else begin
                vecs++; if (data_ok0 !== 1'b1 || rdata0 !== stream_val(c - 1)) begin errs++; $display("FAIL st_resp c=%0d got dok=%0b rdata=%h exp 1 %h", c, data_ok0, rdata0, stream_val(c - 1)); end
            end
            @(negedge clk);
        end
        #1;
        vecs++; if (data_ok0 !== 1'b0) begin errs++; $display("FAIL st_drain got=%0b exp=0", data_ok0); end
    endtask

    task automatic test_unaligned();
        do_reset();
        preload(32'h1C00_0004, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h1C00_0006, 4'h0, 32'h0);
        size = 2'd1; #1;
        vecs++; if (ram_addr0 !== 32'h1C00_0004 || ram_en0 !== 1'b1) begin errs++; $display("FAIL ua_addr got=%h en=%0b exp 1c000004 1", ram_addr0, ram_en0); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        vecs++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin errs++; $display("FAIL ua_resp got dok=%0b rdata=%h exp 1 12345678", data_ok0, rdata0); end
    endtask

    initial begin
        pre_vld = 1'b0; pre_addr = 32'h0; pre_dat = 32'h0;
        test_reset();
        test_reset_mid();
        test_single_read();
        test_back_to_back();
        test_write_then_read();
        test_stream();
        test_unaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
